// File: rtl/n_bit_timer_defs_pkg.sv
// -----------------------------------------------------------------------------
// n_bit_timer_defs
//   Shared definitions for the N-bit down-timer. The down-timer is the
//   counterpart of the N-bit up-counter.
//
//   Contents:
//     STATE_IDLE / STATE_RUN  state encoding constants
//     timer_state_t           two-state FSM type built on those constants
//     TIMER_DEFAULT_N         default width of count, load value and q
// -----------------------------------------------------------------------------
package n_bit_timer_defs;

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_RUN  = 1'b1;

    typedef enum logic {
        IDLE = STATE_IDLE,
        RUN  = STATE_RUN
    } timer_state_t;

    localparam int TIMER_DEFAULT_N = 8;

endpackage : n_bit_timer_defs

// File: rtl/n_bit_down_timer.sv
// -----------------------------------------------------------------------------
// n_bit_down_timer
//   Loadable N-bit down-counter / one-shot timer with optional auto-reload.
//   A count is accepted over a valid/ready load handshake. The count then
//   decrements on each enabled cycle. A registered one-cycle done pulse marks
//   the terminal count. With auto_reload set, the latched load value is
//   restored at terminal count, so the timer acts as a periodic tick source.
//
//   Ports:
//     clk          in   1  rising-edge clock
//     rst          in   1  asynchronous, active-high reset
//     load         in   1  load request (valid)
//     load_value   in   N  count to load; sampled when load & ready
//     ready        out  1  timer can accept a load (IDLE)
//     en           in   1  count enable; 0 pauses the count
//     auto_reload  in   1  reload the latched value at terminal count
//     abort        in   1  stop at once, return to IDLE, no done
//     q            out  N  current count
//     busy         out  1  timer is counting (RUN)
//     done         out  1  one-cycle pulse at terminal count
// -----------------------------------------------------------------------------
module n_bit_down_timer
    import n_bit_timer_defs::*;
#(
    parameter int N = TIMER_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_value,
    output logic         ready,
    input  logic         en,
    input  logic         auto_reload,
    input  logic         abort,
    output logic [N-1:0] q,
    output logic         busy,
    output logic         done
);

    localparam logic [N-1:0] ZERO = '0;
    localparam logic [N-1:0] ONE  = N'(1);

    timer_state_t state;
    timer_state_t state_nxt;
    logic [N-1:0] q_nxt;
    logic [N-1:0] reload_reg;
    logic [N-1:0] reload_nxt;
    logic         done_nxt;

    // Handshake and status flags are pure decodes of the state register.
    assign ready = (state == IDLE);
    assign busy  = (state == RUN);

    // Next-state and next-count decode. done_nxt defaults low, so every path
    // that does not reach terminal count clears the pulse on the next edge.
    always_comb begin
        state_nxt  = state;
        q_nxt      = q;
        reload_nxt = reload_reg;
        done_nxt   = 1'b0;

        unique case (state)
            IDLE: begin
                // abort has no meaning in IDLE, so a load issued together
                // with abort is still accepted.
                if (load) begin
                    if (load_value == ZERO) begin
                        // A zero-length timeout expires on the load edge
                        // and never enters RUN.
                        q_nxt    = ZERO;
                        done_nxt = 1'b1;
                    end else begin
                        q_nxt      = load_value;
                        reload_nxt = load_value;
                        state_nxt  = RUN;
                    end
                end
            end

            RUN: begin
                // Loads are ignored here (ready is low). abort takes priority
                // over the enable and over the terminal count.
                if (abort) begin
                    q_nxt     = ZERO;
                    state_nxt = IDLE;
                end else if (en) begin
                    if (q == ONE) begin
                        done_nxt = 1'b1;
                        if (auto_reload) begin
                            q_nxt = reload_reg;
                        end else begin
                            q_nxt     = ZERO;
                            state_nxt = IDLE;
                        end
                    end else if (q > ONE) begin
                        q_nxt = q - ONE;
                    end
                    // q == 0 cannot occur in RUN; holding it keeps the count
                    // from wrapping.
                end
            end

            default: begin
                state_nxt = IDLE;
                q_nxt     = ZERO;
            end
        endcase
    end

    // A reset in mid-count discards the count and produces no done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            q          <= ZERO;
            reload_reg <= ZERO;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            q          <= q_nxt;
            reload_reg <= reload_nxt;
            done       <= done_nxt;
        end
    end

endmodule : n_bit_down_timer

// File: tb/tb_n_bit_down_timer.sv
module tb_n_bit_down_timer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         load = 1'b0;
    logic [N-1:0] load_value = '0;
    logic         ready;
    logic         en = 1'b0;
    logic         auto_reload = 1'b0;
    logic         abort = 1'b0;
    logic [N-1:0] q;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    n_bit_down_timer #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .load_value  (load_value),
        .ready       (ready),
        .en          (en),
        .auto_reload (auto_reload),
        .abort       (abort),
        .q           (q),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Behavioural reference: a remaining-count plus a running flag.
    int m_q      = 0;
    int m_reload = 0;
    bit m_run    = 0;
    bit m_done   = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q = 0; m_reload = 0; m_run = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (!m_run) begin
                if (load) begin
                    if (load_value == 0) begin
                        m_q = 0; m_done = 1;
                    end else begin
                        m_q = int'(load_value); m_reload = int'(load_value); m_run = 1;
                    end
                end
            end else if (abort) begin
                m_q = 0; m_run = 0;
            end else if (en) begin
                m_q = m_q - 1;
                if (m_q == 0) begin
                    m_done = 1;
                    if (auto_reload) m_q = m_reload;
                    else m_run = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            n_tests++;
            if (int'(q) != m_q || done != m_done || busy != m_run || ready != !m_run) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t: q=%0d done=%0b busy=%0b ready=%0b, want q=%0d done=%0b busy=%0b ready=%0b",
                         $time, q, done, busy, ready, m_q, m_done, m_run, !m_run);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until done is seen; returns the number of edges taken.
    task automatic wait_done(input string name, input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!done && cyc < max_cyc);
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no done within %0d cycles", name, max_cyc);
        end
    endtask

    task automatic idle_inputs();
        load = 0; load_value = '0; en = 0; auto_reload = 0; abort = 0;
    endtask

    int cyc;
    int dones;

    initial begin
        // Reset state
        #2 rst = 1;
        #1;
        check("reset_q", int'(q), 0);
        check("reset_ready", int'(ready), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        step();
        rst = 0;
        step();

        // 1: V=5 one-shot
        load = 1; load_value = 8'd5; en = 1;
        step();
        load = 0; load_value = '0;
        check("s1_q_after_load", int'(q), 5);
        check("s1_busy", int'(busy), 1);
        check("s1_ready", int'(ready), 0);
        for (int i = 4; i >= 1; i--) begin
            step();
            check("s1_q_count", int'(q), i);
            check("s1_no_early_done", int'(done), 0);
        end
        step();
        check("s1_q_zero", int'(q), 0);
        check("s1_done", int'(done), 1);
        check("s1_ready_back", int'(ready), 1);
        step();
        check("s1_done_one_cycle", int'(done), 0);

        // 2: V=0 load
        idle_inputs();
        load = 1; load_value = 8'd0;
        step();
        load = 0;
        check("s2_done", int'(done), 1);
        check("s2_busy", int'(busy), 0);
        check("s2_ready", int'(ready), 1);
        step();
        check("s2_done_cleared", int'(done), 0);
        check("s2_busy_still_low", int'(busy), 0);

        // 3: V=4 auto-reload, 12 enabled cycles
        load = 1; load_value = 8'd4; en = 1; auto_reload = 1;
        step();
        load = 0;
        dones = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            check("s3_done_pos", int'(done), (i % 4 == 0) ? 1 : 0);
            if (done) begin
                dones++;
                check("s3_reload_q", int'(q), 4);
            end
        end
        check("s3_done_count", dones, 3);
        abort = 1;
        step();
        abort = 0;
        check("s3_abort_idle", int'(ready), 1);

        // 4: V=6 with a 3-cycle pause
        idle_inputs();
        load = 1; load_value = 8'd6; en = 1;
        step();
        load = 0;
        step(); step();
        en = 0;
        step(); step(); step();
        check("s4_q_held", int'(q), 4);
        en = 1;
        cyc = 5;
        wait_done("s4_wait", 20, dones);
        check("s4_total_latency", cyc + dones, 9);

        // 5a: abort at q==1 with en
        idle_inputs();
        load = 1; load_value = 8'd3; en = 1;
        step();
        load = 0;
        step(); step();
        check("s5_q_one", int'(q), 1);
        abort = 1;
        step();
        abort = 0;
        check("s5_abort_q", int'(q), 0);
        check("s5_abort_no_done", int'(done), 0);
        check("s5_abort_idle", int'(ready), 1);
        // 5b: load during RUN ignored
        load = 1; load_value = 8'd5;
        step();
        load_value = 8'd9;
        step(); step(); step();
        check("s5_q_two", int'(q), 2);
        step();
        load = 0;
        check("s5_load_ignored", int'(q), 1);
        step();
        check("s5_finish_done", int'(done), 1);
        // abort with load in IDLE: load still accepted
        abort = 1; load = 1; load_value = 8'd2;
        step();
        abort = 0; load = 0;
        check("s5_idle_abort_load", int'(q), 2);
        wait_done("s5_after_idle_abort", 10, cyc);

        // V=1 with auto-reload: done every cycle
        idle_inputs();
        load = 1; load_value = 8'd1; en = 1; auto_reload = 1;
        step();
        load = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("v1_auto_done", int'(done), 1);
        end
        auto_reload = 0;
        step();
        check("v1_stop_idle", int'(ready), 1);

        // 6: async reset while q=0x80
        idle_inputs();
        load = 1; load_value = 8'h90; en = 1;
        step();
        load = 0;
        for (int i = 0; i < 16; i++) step();
        check("s6_q_80", int'(q), 'h80);
        #2 rst = 1;
        #1;
        check("s6_rst_q", int'(q), 0);
        check("s6_rst_busy", int'(busy), 0);
        check("s6_rst_ready", int'(ready), 1);
        #1 rst = 0;
        load = 1; load_value = 8'hFF;
        step();
        load = 0;
        wait_done("s6_wait_ff", 300, cyc);
        check("s6_ff_latency", cyc, 255);
        step();

        // Randomized phase checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            load        = ($urandom_range(0, 3) == 0);
            load_value  = ($urandom_range(0, 7) == 0) ? N'($urandom) : N'($urandom_range(0, 6));
            en          = ($urandom_range(0, 4) != 0);
            auto_reload = ($urandom_range(0, 2) == 0);
            abort       = ($urandom_range(0, 30) == 0);
            step();
        end
        idle_inputs();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_n_bit_down_timer
